// File: rtl/meas_seq_host.sv
// meas_seq_host: host-side run sequencer for the phase-noise measurement chain.
// Latency: start_config 1 cycle after cmd_start, start_op CONFIG_WAIT cycles later; drain read 1 cycle.
// Backpressure: rd_rdy low holds rd_data/rd_last/rd_rep; capture side has none (excess samples dropped, ovf).
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_start/_phase_inc/_reps      begin a sequence (accepted only when idle)
//   cmd_abort                       abandon the current sequence
//   busy, done, aborted, ovf        status; done/aborted are single-cycle pulses, ovf is sticky
//   stray_data                      pulse: a sample arrived outside capture
//   start_config, phase_inc         config strobe and latched increment to the controller
//   start_op                        start strobe to the controller
//   restart_vld, restart_type       restart strobe (0=REDO, 2=CLOSE) to the controller
//   finish_op, data_in, data_in_vld controller finish level and forwarded sample stream
//   rd_data/_vld/_rdy/_last/_rep    drained capture stream to the host
module meas_seq_host #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SAMPLES = 1024,
  parameter int CONFIG_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [DATA_WIDTH-1:0] cmd_phase_inc,
  input  logic [7:0]            cmd_reps,
  input  logic                  cmd_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  ovf,
  output logic                  stray_data,
  output logic                  start_config,
  output logic [DATA_WIDTH-1:0] phase_inc,
  output logic                  start_op,
  output logic                  restart_vld,
  output logic [1:0]            restart_type,
  input  logic                  finish_op,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic                  rd_last,
  output logic [7:0]            rd_rep
);

  localparam int ADDR_W = $clog2(NUM_SAMPLES);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CFG_W  = $clog2(CONFIG_WAIT) + 1;

  localparam logic [PTR_W-1:0] DEPTH    = PTR_W'(NUM_SAMPLES);
  localparam logic [CFG_W-1:0] CFG_LAST = CFG_W'(CONFIG_WAIT - 1);
  localparam logic [1:0]       RS_REDO  = 2'd0;
  localparam logic [1:0]       RS_CLOSE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_ARM, S_CAPTURE, S_DRAIN, S_RESTART
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [NUM_SAMPLES];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CFG_W-1:0]      cfg_cnt;
  logic [7:0]            reps_q;
  logic [7:0]            rep;

  logic wr_en, rd_load, beat_acc, last_acc, last_run;
  logic busy_nxt, start_config_nxt, start_op_nxt, restart_vld_nxt, done_nxt, aborted_nxt;

  // Samples beyond the buffer depth are dropped; the pointer saturates at DEPTH.
  assign wr_en    = (state == S_CAPTURE) && data_in_vld && (wr_ptr < DEPTH);
  // Output register reloads whenever it is empty or being consumed this cycle,
  // which gives one beat per cycle with rd_rdy held high.
  assign rd_load  = (state == S_DRAIN) && (rd_ptr < wr_ptr) && (!rd_vld || rd_rdy);
  assign beat_acc = rd_vld && rd_rdy;
  assign last_acc = beat_acc && rd_last;
  // reps_q is clamped to at least 1 when latched.
  assign last_run = ({1'b0, rep} + 9'd1) >= {1'b0, reps_q};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_start) state_nxt = S_CFG;
      S_CFG:     if (cfg_cnt == CFG_LAST) state_nxt = S_ARM;
      S_ARM:     state_nxt = S_CAPTURE;
      S_CAPTURE: if (finish_op) state_nxt = S_DRAIN;
      S_DRAIN:   if (wr_ptr == '0 || last_acc) state_nxt = S_RESTART;
      S_RESTART: state_nxt = last_run ? S_IDLE : S_ARM;
      default:   state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && cmd_abort) state_nxt = S_IDLE;

    // Strobes are derived from the next state so they are registered yet
    // coincide with the state they belong to.
    busy_nxt         = (state_nxt != S_IDLE);
    start_config_nxt = (state == S_IDLE) && (state_nxt == S_CFG);
    start_op_nxt     = (state_nxt == S_ARM);
    restart_vld_nxt  = (state_nxt == S_RESTART);
    done_nxt         = (state == S_RESTART) && last_run && !cmd_abort;
    aborted_nxt      = (state != S_IDLE) && cmd_abort;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      ovf          <= 1'b0;
      stray_data   <= 1'b0;
      start_config <= 1'b0;
      phase_inc    <= '0;
      start_op     <= 1'b0;
      restart_vld  <= 1'b0;
      restart_type <= RS_REDO;
      rd_data      <= '0;
      rd_vld       <= 1'b0;
      rd_last      <= 1'b0;
      rd_rep       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cfg_cnt      <= '0;
      reps_q       <= '0;
      rep          <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      aborted      <= aborted_nxt;
      start_config <= start_config_nxt;
      start_op     <= start_op_nxt;
      restart_vld  <= restart_vld_nxt;
      restart_type <= restart_vld_nxt ? (last_run ? RS_CLOSE : RS_REDO) : RS_REDO;
      stray_data   <= data_in_vld && (state != S_CAPTURE);

      if (state == S_IDLE && cmd_start) begin
        phase_inc <= cmd_phase_inc;
        reps_q    <= (cmd_reps == 8'd0) ? 8'd1 : cmd_reps;
        ovf       <= 1'b0;
        rep       <= '0;
        wr_ptr    <= '0;
      end

      cfg_cnt <= (state == S_CFG) ? cfg_cnt + CFG_W'(1) : '0;

      if (state == S_CAPTURE && data_in_vld) begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        else       ovf    <= 1'b1;
      end

      if (state == S_RESTART && !last_run && !cmd_abort) begin
        rep    <= rep + 8'd1;
        wr_ptr <= '0;
      end

      // Leaving DRAIN (last beat, empty capture or abort) drops the stream
      // and rewinds the read pointer for the next run.
      if (state_nxt != S_DRAIN) begin
        rd_vld  <= 1'b0;
        rd_last <= 1'b0;
        rd_ptr  <= '0;
      end else if (rd_load) begin
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_vld  <= 1'b1;
        rd_last <= (rd_ptr == wr_ptr - PTR_W'(1));
        rd_rep  <= rep;
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end else if (beat_acc) begin
        rd_vld  <= 1'b0;
        rd_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_meas_seq_host.sv
// Testbench for meas_seq_host: table of sequence scenarios run against a
// controller/host model, plus hand-written abort, stray, empty-run and reset cases.
module tb_meas_seq_host;
  localparam int DW = 32;
  localparam int NS = 1024;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start, cmd_abort;
  logic [DW-1:0] cmd_phase_inc;
  logic [7:0]    cmd_reps;
  logic          busy, done, aborted, ovf, stray_data;
  logic          start_config, start_op, restart_vld;
  logic [DW-1:0] phase_inc;
  logic [1:0]    restart_type;
  logic          finish_op, data_in_vld;
  logic [DW-1:0] data_in;
  logic [DW-1:0] rd_data;
  logic          rd_vld, rd_rdy, rd_last;
  logic [7:0]    rd_rep;

  always #5 clk = ~clk;

  meas_seq_host #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS), .CONFIG_WAIT(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_phase_inc(cmd_phase_inc), .cmd_reps(cmd_reps),
    .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .aborted(aborted), .ovf(ovf), .stray_data(stray_data),
    .start_config(start_config), .phase_inc(phase_inc), .start_op(start_op),
    .restart_vld(restart_vld), .restart_type(restart_type),
    .finish_op(finish_op), .data_in(data_in), .data_in_vld(data_in_vld),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_last(rd_last), .rd_rep(rd_rep)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, 64'({busy, done, aborted, ovf, stray_data, start_config,
                               start_op, restart_vld, rd_vld, rd_last}), 64'd0);
    chk({name, "_restart_type"}, 64'(restart_type), 64'd0);
    chk({name, "_phase_inc"},    64'(phase_inc), 64'd0);
    chk({name, "_rd_data"},      64'(rd_data), 64'd0);
    chk({name, "_rd_rep"},       64'(rd_rep), 64'd0);
  endtask

  // Issue cmd_start and follow it to the start_op cycle (returns on that negedge).
  task automatic start_cmd(input logic [DW-1:0] ph, input logic [7:0] reps);
    int k;
    @(negedge clk);
    cmd_phase_inc = ph; cmd_reps = reps; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_phase_inc = 32'hDEAD_BEEF; cmd_reps = 8'hFF;
    chk("start_config_T1", 64'(start_config), 64'd1);
    chk("busy_T1",         64'(busy), 64'd1);
    chk("ovf_cleared",     64'(ovf), 64'd0);
    k = 1;
    while (!start_op && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) chk("start_config_one_cycle", 64'(start_config), 64'd0);
    end
    chk("start_op_latency", 64'(k), 64'(1 + CW));
  endtask

  typedef struct {
    logic [DW-1:0] phase;
    logic [7:0]    reps;
    int            runs;
    int            nsamp;
    int            exp_beats;
    bit            exp_ovf;
    bit            rnd_rdy;
    bit            fin_last;
    logic [DW-1:0] base;
  } vec_t;

  vec_t vecs[5];

  task automatic run_seq(input vec_t v);
    int idx, cyc, first_vld, limit;
    bit rdy, stalled;
    logic [DW-1:0] hold_dat, base, exp_dat;
    logic hold_last;
    start_cmd(v.phase, v.reps);
    for (int rep = 0; rep < v.runs; rep++) begin
      chk("start_op", 64'(start_op), 64'd1);
      chk("phase_inc", 64'(phase_inc), 64'(v.phase));
      base = v.base + 32'(rep) * 32'h1000;
      @(negedge clk);
      for (int i = 0; i < v.nsamp; i++) begin
        data_in = base + 32'(i); data_in_vld = 1'b1;
        finish_op = v.fin_last && (i == v.nsamp - 1);
        @(negedge clk);
      end
      data_in_vld = 1'b0;
      if (!v.fin_last) begin finish_op = 1'b1; @(negedge clk); end
      finish_op = 1'b0;
      idx = 0; cyc = 0; first_vld = -1; stalled = 1'b0; limit = v.exp_beats * 8 + 50;
      while (idx < v.exp_beats && cyc < limit) begin
        if (stalled) begin
          chk("stall_vld",  64'(rd_vld), 64'd1);
          chk("stall_dat",  64'(rd_data), 64'(hold_dat));
          chk("stall_last", 64'(rd_last), 64'(hold_last));
        end
        if (rd_vld && first_vld < 0) begin
          first_vld = cyc;
          chk("first_beat_within_2", 64'(cyc <= 2), 64'd1);
        end
        rdy = v.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_rdy = rdy;
        stalled = rd_vld && !rdy;
        hold_dat = rd_data; hold_last = rd_last;
        if (rd_vld && rdy) begin
          exp_dat = base + 32'(idx);
          chk("beat_data", 64'(rd_data), 64'(exp_dat));
          chk("beat_last", 64'(rd_last), 64'(idx == v.exp_beats - 1));
          chk("beat_rep",  64'(rd_rep), 64'(rep));
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
      rd_rdy = 1'b0;
      chk("beats_drained", 64'(idx), 64'(v.exp_beats));
      chk("restart_vld",   64'(restart_vld), 64'd1);
      chk("restart_type",  64'(restart_type), (rep == v.runs - 1) ? 64'd2 : 64'd0);
      chk("rd_vld_after_last", 64'(rd_vld), 64'd0);
      @(negedge clk);
      chk("restart_one_cycle", 64'(restart_vld), 64'd0);
    end
    chk("done",          64'(done), 64'd1);
    chk("busy_at_done",  64'(busy), 64'd0);
    chk("ovf_at_done",   64'(ovf), 64'(v.exp_ovf));
    chk("phase_inc_end", 64'(phase_inc), 64'(v.phase));
    @(negedge clk);
    chk("done_pulse_len", 64'(done), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    //          phase          reps runs nsamp beats ovf rnd fin_last base
    vecs[0] = '{32'h0000_1000, 8'd1, 1, 1024, 1024, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1] = '{32'hABCD_0123, 8'd3, 3,    8,    8, 1'b0, 1'b0, 1'b1, 32'h0000_0100};
    vecs[2] = '{32'h0000_0001, 8'd1, 1, 1030, 1024, 1'b1, 1'b0, 1'b0, 32'h0000_5000};
    vecs[3] = '{32'h7FFF_FFFF, 8'd1, 1,   16,   16, 1'b0, 1'b1, 1'b0, 32'hC000_0000};
    vecs[4] = '{32'h0000_0042, 8'd0, 1,    5,    5, 1'b0, 1'b0, 1'b1, 32'h0000_0077};

    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cmd_phase_inc = '0; cmd_reps = '0;
    finish_op = 1'b0; data_in = '0; data_in_vld = 1'b0; rd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_seq(vecs[i]);

    // Empty capture: no beats, restart one cycle after DRAIN is entered.
    start_cmd(32'h0000_0033, 8'd1);
    @(negedge clk);
    finish_op = 1'b1;
    @(negedge clk);
    finish_op = 1'b0;
    chk("empty_no_vld_a",  64'(rd_vld), 64'd0);
    chk("empty_restart_a", 64'(restart_vld), 64'd0);
    @(negedge clk);
    chk("empty_no_vld_b",  64'(rd_vld), 64'd0);
    chk("empty_restart_b", 64'(restart_vld), 64'd1);
    chk("empty_close",     64'(restart_type), 64'd2);
    @(negedge clk);
    chk("empty_done", 64'(done), 64'd1);

    // Abort mid-drain.
    start_cmd(32'h0000_0BAD, 8'd2);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      data_in = 32'(i); data_in_vld = 1'b1; @(negedge clk);
    end
    data_in_vld = 1'b0; finish_op = 1'b1;
    @(negedge clk);
    finish_op = 1'b0; rd_rdy = 1'b1;
    k = 0;
    while (!rd_vld && k < 10) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    rd_rdy = 1'b0; cmd_abort = 1'b1;
    chk("abort_pre_vld", 64'(rd_vld), 64'd1);
    @(negedge clk);
    cmd_abort = 1'b0;
    chk("abort_vld_drop", 64'(rd_vld), 64'd0);
    chk("abort_pulse",    64'(aborted), 64'd1);
    chk("abort_busy",     64'(busy), 64'd0);
    chk("abort_no_done",  64'(done), 64'd0);
    @(negedge clk);
    chk("abort_pulse_end", 64'(aborted), 64'd0);
    chk("abort_no_done_b", 64'(done), 64'd0);
    chk("abort_no_restart", 64'(restart_vld), 64'd0);

    // Sample in IDLE.
    data_in = 32'h1111_2222; data_in_vld = 1'b1;
    @(negedge clk);
    data_in_vld = 1'b0;
    chk("stray_pulse", 64'(stray_data), 64'd1);
    @(negedge clk);
    chk("stray_end", 64'(stray_data), 64'd0);

    // Reset during capture.
    start_cmd(32'h1234_5678, 8'd2);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data_in = 32'(i); data_in_vld = 1'b1; @(negedge clk);
    end
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_in_vld = 1'b0;
    chk_all_zero("midop_reset");
    @(negedge clk);
    chk("post_reset_no_pulse", 64'({done, aborted, busy}), 64'd0);

    run_seq(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
